// File: rtl/piso_serializer_if.sv
// Parallel-load / serial-out handshake bundle for piso_serializer.
// master drives the parallel word, slave is the serializer.
interface piso_serializer_if #(
   parameter int n = 4
);
   logic [n-1:0] din;
   logic         load_valid;
   logic         load_ready;
   logic         sout;
   logic         sout_valid;
   logic         done;
   logic         busy;

   modport master (
      output din,
      output load_valid,
      input  load_ready,
      input  sout,
      input  sout_valid,
      input  done,
      input  busy
   );

   modport slave (
      input  din,
      input  load_valid,
      output load_ready,
      output sout,
      output sout_valid,
      output done,
      output busy
   );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter: first bit one cycle after accept, n bits per word, back-to-back reload on the last bit.
// Optional PISO_PARITY_EN appends an even-parity bit; load_ready opens only in IDLE or on the final bit of a word.
module piso_serializer #(
   parameter int n         = 4,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   piso_serializer_if.slave  bus
);

`ifdef PISO_PARITY_EN
   localparam int WLEN = n + 1;
`else
   localparam int WLEN = n;
`endif
   localparam int            CW   = $clog2(WLEN);
   localparam logic [CW-1:0] LAST = CW'(WLEN - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t          state, state_nxt;
   logic [n-1:0]    shreg, shreg_nxt;
   logic [CW-1:0]   cnt,   cnt_nxt;
   logic            data_bit;
`ifdef PISO_PARITY_EN
   logic            par,   par_nxt;
`endif

   // The bit on the wire always comes from the registered shifter, never from din.
   assign data_bit = LSB_FIRST ? shreg[0] : shreg[n-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         shreg <= '0;
         cnt   <= '0;
`ifdef PISO_PARITY_EN
         par   <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         shreg <= shreg_nxt;
         cnt   <= cnt_nxt;
`ifdef PISO_PARITY_EN
         par   <= par_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt      = state;
      shreg_nxt      = shreg;
      cnt_nxt        = cnt;
`ifdef PISO_PARITY_EN
      par_nxt        = par;
`endif
      bus.load_ready = 1'b0;
      bus.sout       = 1'b0;
      bus.sout_valid = 1'b0;
      bus.done       = 1'b0;
      bus.busy       = 1'b0;

      case (state)
         IDLE: begin
            bus.load_ready = 1'b1;
            if (bus.load_valid) begin
               state_nxt = SHIFT;
               shreg_nxt = bus.din;
               cnt_nxt   = '0;
`ifdef PISO_PARITY_EN
               par_nxt   = ^bus.din;
`endif
            end
         end

         SHIFT: begin
            bus.busy       = 1'b1;
            bus.sout_valid = 1'b1;
`ifdef PISO_PARITY_EN
            bus.sout       = (cnt == CW'(n)) ? par : data_bit;
`else
            bus.sout       = data_bit;
`endif
            if (cnt == LAST) begin
               // Final bit: the window for the next word is open this cycle only.
               bus.done       = 1'b1;
               bus.load_ready = 1'b1;
               cnt_nxt        = '0;
               if (bus.load_valid) begin
                  shreg_nxt = bus.din;
`ifdef PISO_PARITY_EN
                  par_nxt   = ^bus.din;
`endif
               end else begin
                  state_nxt = IDLE;
                  shreg_nxt = '0;
               end
            end else begin
               cnt_nxt   = cnt + CW'(1);
               shreg_nxt = LSB_FIRST ? (shreg >> 1) : (shreg << 1);
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboarded bench: two serializers (LSB-first and MSB-first) driven with directed words and hand-written bit sequences.
module tb_piso_serializer;
   localparam int N = 4;

   typedef struct {
      logic        b;
      logic        d;
      int unsigned cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   int unsigned cyc = 0;
   int          total = 0;
   int          bad = 0;
   exp_t        ql[$];
   exp_t        qm[$];

   piso_serializer_if #(.n(N)) bl ();
   piso_serializer_if #(.n(N)) bm ();

   piso_serializer #(.n(N), .LSB_FIRST(1'b1)) u_lsb (.clk(clk), .rst(rst), .bus(bl));
   piso_serializer #(.n(N), .LSB_FIRST(1'b0)) u_msb (.clk(clk), .rst(rst), .bus(bm));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic act, input logic req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%b required=%b cyc=%0d", name, act, req, cyc);
      end
   endtask

   task automatic chk_int(input string name, input int unsigned act, input int unsigned req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic mon_step(input bit m, input string tag, input logic sv, input logic so, input logic dn);
      exp_t e;
      bit   has;
      has = m ? (qm.size() > 0) : (ql.size() > 0);
      if (sv) begin
         if (!has) begin
            chk({tag, " unexpected sout_valid"}, 1'b1, 1'b0);
         end else begin
            e = m ? qm.pop_front() : ql.pop_front();
            chk({tag, " sout"}, so, e.b);
            chk({tag, " done"}, dn, e.d);
            chk_int({tag, " bit cycle"}, cyc, e.cyc);
         end
      end else begin
         chk({tag, " idle done"}, dn, 1'b0);
         chk({tag, " idle sout"}, so, 1'b0);
         if (has) begin
            e = m ? qm[0] : ql[0];
            if (e.cyc <= cyc) begin
               chk({tag, " missing bit"}, 1'b0, 1'b1);
               if (m) void'(qm.pop_front()); else void'(ql.pop_front());
            end
         end
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         mon_step(1'b0, "lsb", bl.sout_valid, bl.sout, bl.done);
         mon_step(1'b1, "msb", bm.sout_valid, bm.sout, bm.done);
      end
   end

   // seq lists the expected wire bits with the first-emitted bit at the MSB.
   task automatic push(input bit m, input logic [N-1:0] seq, input logic par, input int unsigned c0);
      exp_t e;
      for (int i = 0; i < N; i++) begin
         e.b   = seq[N-1-i];
`ifdef PISO_PARITY_EN
         e.d   = 1'b0;
`else
         e.d   = (i == N-1);
`endif
         e.cyc = c0 + i;
         if (m) qm.push_back(e); else ql.push_back(e);
      end
`ifdef PISO_PARITY_EN
      e.b   = par;
      e.d   = 1'b1;
      e.cyc = c0 + N;
      if (m) qm.push_back(e); else ql.push_back(e);
`else
      if (par === 1'bx) $display("parity argument unknown");
`endif
   endtask

   task automatic drive(input bit m, input logic v, input logic [N-1:0] d);
      if (m) begin bm.load_valid = v; bm.din = d; end
      else   begin bl.load_valid = v; bl.din = d; end
   endtask

   task automatic send(input bit m, input logic [N-1:0] data, input logic [N-1:0] seq,
                       input logic par, input bit keep);
      bit   acc;
      logic rdy;
      acc = 1'b0;
      for (int k = 0; k < 64 && !acc; k++) begin
         rdy = m ? bm.load_ready : bl.load_ready;
         if (rdy) begin
            drive(m, 1'b1, data);
            push(m, seq, par, cyc + 1);
            acc = 1'b1;
         end else begin
            drive(m, 1'b1, N'($urandom));
         end
         @(posedge clk);
         #1;
      end
      if (!acc) chk("accept timeout", 1'b0, 1'b1);
      if (!keep) drive(m, 1'b0, N'($urandom));
   endtask

   task automatic idle(input int c);
      repeat (c) @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string tag, input bit m);
      chk({tag, " rst sout"},       m ? bm.sout       : bl.sout,       1'b0);
      chk({tag, " rst sout_valid"}, m ? bm.sout_valid : bl.sout_valid, 1'b0);
      chk({tag, " rst done"},       m ? bm.done       : bl.done,       1'b0);
      chk({tag, " rst busy"},       m ? bm.busy       : bl.busy,       1'b0);
      chk({tag, " rst load_ready"}, m ? bm.load_ready : bl.load_ready, 1'b1);
   endtask

   initial begin
      drive(1'b0, 1'b0, '0);
      drive(1'b1, 1'b0, '0);
      #1 rst = 1'b1;
      #1;
      drive(1'b0, 1'b1, 4'hF);
      drive(1'b1, 1'b1, 4'h9);
      #1;
      chk_reset("lsb", 1'b0);
      chk_reset("msb", 1'b1);
      drive(1'b0, 1'b0, '0);
      drive(1'b1, 1'b0, '0);
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b0;
      idle(2);

      send(1'b0, 4'b1101, 4'b1011, 1'b1, 1'b0);
      idle(8);
      send(1'b1, 4'b1000, 4'b1000, 1'b1, 1'b0);
      idle(8);
      send(1'b0, 4'hA, 4'b0101, 1'b0, 1'b1);
      send(1'b0, 4'h5, 4'b1010, 1'b0, 1'b0);
      idle(8);
      send(1'b0, 4'b0111, 4'b1110, 1'b1, 1'b0);
      idle(8);

      // Abort a word right after its second bit has been checked.
      send(1'b0, 4'b0110, 4'b0110, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      #1 rst = 1'b1;
      drive(1'b0, 1'b1, 4'h3);
      #1;
      chk_reset("lsb abort", 1'b0);
      drive(1'b0, 1'b0, '0);
      ql.delete();
      @(posedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      idle(4);
      send(1'b0, 4'b0011, 4'b1100, 1'b0, 1'b0);

      for (int k = 0; k < 40 && (ql.size() > 0 || qm.size() > 0); k++) idle(1);
      chk("scoreboard drained", (ql.size() == 0 && qm.size() == 0), 1'b1);
      idle(3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end
endmodule
